// File: rtl/fifo_rd_ptr_empty.sv
// fifo_rd_ptr_empty
// Read-side pointer and empty-flag stage of a dual-clock FIFO.
// The registered Gray write pointer is brought into the read clock through a
// plain flop chain and compared against the next Gray read pointer to form a
// registered, pessimistic empty flag. The Gray read pointer is returned to the
// write domain for full detection.
//
// Optional build macro: FIFO_RD_LEVEL_EN
//   defined   -> rd_level / almost_empty are computed from the synchronised
//                write pointer and registered in step with empty.
//   undefined -> rd_level is tied to 0 and almost_empty to 1.
module fifo_rd_ptr_empty #(
   parameter int unsigned ASIZE       = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned AE_THRESH   = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             rd_en,
   input  logic [ASIZE:0]   wq_gray,
   output logic [ASIZE:0]   rd_gray,
   output logic [ASIZE-1:0] rd_addr,
   output logic             empty,
   output logic [ASIZE:0]   rd_level,
   output logic             almost_empty
);

   // A single-flop chain is not a synchroniser; depths below 2 are raised to 2.
   localparam int unsigned NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   logic [ASIZE:0] sync_q [NSYNC];
   logic [ASIZE:0] wsync;
   logic [ASIZE:0] rbin;
   logic [ASIZE:0] rbin_next;
   logic [ASIZE:0] rgray_next;
   logic           rd_fire;

   // Write-pointer synchroniser: straight flop chain, nothing between stages.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NSYNC; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= wq_gray;
         for (int unsigned i = 1; i < NSYNC; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   // Accept qualification and next binary/Gray read pointer.
   always_comb begin
      wsync      = sync_q[NSYNC-1];
      rd_fire    = rd_en & ~empty;
      rbin_next  = rbin + (ASIZE+1)'(rd_fire);
      rgray_next = (rbin_next >> 1) ^ rbin_next;
      rd_addr    = rbin[ASIZE-1:0];
   end

   // Read pointer registers and empty flag; full-width compare covers wrap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rbin    <= '0;
         rd_gray <= '0;
         empty   <= 1'b1;
      end else begin
         rbin    <= rbin_next;
         rd_gray <= rgray_next;
         empty   <= (rgray_next == wsync);
      end
   end

`ifdef FIFO_RD_LEVEL_EN
   logic [ASIZE:0] wbin;
   logic [ASIZE:0] level_next;

   // Gray-to-binary of the synchronised write pointer and next fill level.
   always_comb begin
      wbin = '0;
      for (int unsigned i = 0; i <= ASIZE; i++) begin
         wbin[i] = ^(wsync >> i);
      end
      level_next = wbin - rbin_next;
   end

   // Level and almost-empty registered alongside empty.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_level     <= '0;
         almost_empty <= 1'b1;
      end else begin
         rd_level     <= level_next;
         almost_empty <= (32'(level_next) <= AE_THRESH);
      end
   end
`else
   // Level reporting disabled: outputs held at their reset values.
   always_comb begin
      rd_level     = '0;
      almost_empty = 1'b1;
   end
`endif

endmodule

// File: tb/tb_fifo_rd_ptr_empty.sv
// tb_fifo_rd_ptr_empty
// Scoreboard bench: the driver applies inputs on the falling edge, advances an
// occupancy-count model for the coming rising edge and queues the expected
// outputs; a monitor pops and compares just after every rising edge.
// Build with or without FIFO_RD_LEVEL_EN to match the RTL build.
module tb_fifo_rd_ptr_empty;

   localparam int unsigned ASIZE = 4;
   localparam int unsigned SYNC  = 2;
   localparam int unsigned AE    = 2;
   localparam int unsigned PMOD  = 1 << (ASIZE + 1);
   localparam int unsigned DEPTH = 1 << ASIZE;

   logic             clk     = 1'b0;
   logic             reset_n = 1'b0;
   logic             rd_en   = 1'b0;
   logic [ASIZE:0]   wq_gray = '0;
   logic [ASIZE:0]   rd_gray;
   logic [ASIZE-1:0] rd_addr;
   logic             empty;
   logic [ASIZE:0]   rd_level;
   logic             almost_empty;

   fifo_rd_ptr_empty #(
      .ASIZE       (ASIZE),
      .SYNC_STAGES (SYNC),
      .AE_THRESH   (AE)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .rd_en        (rd_en),
      .wq_gray      (wq_gray),
      .rd_gray      (rd_gray),
      .rd_addr      (rd_addr),
      .empty        (empty),
      .rd_level     (rd_level),
      .almost_empty (almost_empty)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ASIZE:0]   gray;
      logic [ASIZE-1:0] addr;
      logic             empty;
      logic [ASIZE:0]   level;
      logic             ae;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // Model: write count, read count (both mod 2^(ASIZE+1)), and the write
   // counts as seen through the synchroniser delay.
   int unsigned m_wptr  = 0;
   int unsigned m_rptr  = 0;
   int unsigned m_level = 0;
   bit          m_empty = 1'b1;
   int unsigned m_seen[$];

   function automatic logic [ASIZE:0] gray(int unsigned b);
      logic [ASIZE:0] x;
      x = (ASIZE+1)'(b);
      return x ^ (x >> 1);
   endfunction

   function automatic void chk(string name, int unsigned act, int unsigned req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endfunction

   function automatic void compare(exp_t e, string tag);
      chk({tag, ".rd_gray"},      rd_gray,      e.gray);
      chk({tag, ".rd_addr"},      rd_addr,      e.addr);
      chk({tag, ".empty"},        empty,        e.empty);
      chk({tag, ".rd_level"},     rd_level,     e.level);
      chk({tag, ".almost_empty"}, almost_empty, e.ae);
   endfunction

   function automatic exp_t reset_exp();
      exp_t e;
      e.gray = '0; e.addr = '0; e.empty = 1'b1; e.level = '0; e.ae = 1'b1;
      return e;
   endfunction

   function automatic void model_reset();
      m_rptr  = 0;
      m_empty = 1'b1;
      m_level = 0;
      m_seen.delete();
      for (int unsigned i = 0; i < SYNC; i++) m_seen.push_back(0);
   endfunction

   // Predict outputs after the coming rising edge from the inputs now applied.
   function automatic void model_edge();
      exp_t        e;
      int unsigned seen;
      if (!reset_n) begin
         model_reset();
      end else begin
         seen = m_seen.pop_front();
         m_seen.push_back(m_wptr);
         if (rd_en && !m_empty) m_rptr = (m_rptr + 1) % PMOD;
         m_empty = (m_rptr == seen);
         m_level = (seen + PMOD - m_rptr) % PMOD;
      end
      e.gray  = gray(m_rptr);
      e.addr  = ASIZE'(m_rptr % DEPTH);
      e.empty = m_empty;
`ifdef FIFO_RD_LEVEL_EN
      e.level = (ASIZE+1)'(m_level);
      e.ae    = (m_level <= AE);
`else
      e.level = '0;
      e.ae    = 1'b1;
`endif
      exp_q.push_back(e);
   endfunction

   // One read-clock cycle of stimulus: optional write step and read request.
   task automatic cycle(input bit rd, input bit wr);
      @(negedge clk);
      rd_en = rd;
      if (wr && ((m_wptr + PMOD - m_rptr) % PMOD) < DEPTH) m_wptr = (m_wptr + 1) % PMOD;
      wq_gray = gray(m_wptr);
      model_edge();
   endtask

   // Monitor: compare every output just after each rising edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compare(e, "edge");
      end
   end

   initial begin
      model_reset();
      // Reset held with a non-zero write pointer (gray(2) = 5'b00011).
      m_wptr  = 2;
      wq_gray = gray(m_wptr);
      repeat (4) cycle(1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      model_edge();
      repeat (5) cycle(1'b0, 1'b0);

      // Fill to level 7, then assert reset asynchronously with rd_en high.
      repeat (5) cycle(1'b0, 1'b1);
      repeat (4) cycle(1'b0, 1'b0);
      @(negedge clk);
      rd_en = 1'b1;
      #2 reset_n = 1'b0;
      #1 compare(reset_exp(), "async_rst");
      model_edge();
      repeat (2) cycle(1'b1, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      rd_en   = 1'b0;
      model_edge();
      repeat (6) cycle(1'b0, 1'b0);

      // Drain, then underflow attempts with rd_en held on an empty FIFO.
      repeat (12) cycle(1'b1, 1'b0);
      repeat (10) cycle(1'b1, 1'b0);

      // Single word: one write, wait for visibility, one read.
      cycle(1'b0, 1'b1);
      repeat (4) cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      repeat (3) cycle(1'b0, 1'b0);

      // Random traffic across several pointer wraps.
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
      end

      // Fill to full (difference of 2^ASIZE is not empty), then drain.
      repeat (20) cycle(1'b0, 1'b1);
      repeat (4)  cycle(1'b0, 1'b0);
      repeat (24) cycle(1'b1, 1'b0);

      // Level 5, then three reads down to level 2.
      repeat (5) cycle(1'b0, 1'b1);
      repeat (5) cycle(1'b0, 1'b0);
      repeat (3) cycle(1'b1, 1'b0);
      repeat (4) cycle(1'b0, 1'b0);

      // Let the monitor drain the queue, bounded.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain actual=%0d required=0 pending", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/fifo_rd_ptr_empty.md
# fifo_rd_ptr_empty

Read-side pointer and empty-flag stage of the dual-clock FIFO. It consumes the registered Gray-coded write pointer from the write-clock domain and synchronises it into the read clock. It keeps the binary/Gray read pointer, supplies the RAM read address, and returns its Gray read pointer to the write domain for full detection.

## Interface
- ASIZE, 4, RAM address width; pointers are ASIZE+1 bits (MSB is the wrap bit)
- SYNC_STAGES, 2, synchroniser depth for the incoming write pointer (minimum 2)
- AE_THRESH, 2, almost-empty threshold in words (used only with FIFO_RD_LEVEL_EN)

- clk  in  1  read-domain clock
- reset_n  in  1  reset, asynchronous, active-low; clock clk
- rd_en  in  1  read request from consumer
- wq_gray  in  ASIZE+1  Gray write pointer, registered in write domain
- rd_gray  out  ASIZE+1  registered Gray read pointer, to write domain
- rd_addr  out  ASIZE  RAM read address
- empty  out  1  registered empty flag
- rd_level  out  ASIZE+1  words available (FIFO_RD_LEVEL_EN only)
- almost_empty  out  1  rd_level <= AE_THRESH (FIFO_RD_LEVEL_EN only)

## Operation
- Synchroniser: SYNC_STAGES-flop chain on wq_gray, all stages reset to 0; wsync = last stage. No logic between stages.
- Accept: rd_fire = rd_en & !empty. rd_en while empty is ignored; pointer and flags unchanged, no underflow.
- Pointer: rbin_next = rbin + rd_fire, modulo 2^(ASIZE+1); rgray_next = (rbin_next >> 1) ^ rbin_next. rbin and rd_gray register rbin_next and rgray_next each clk.
- rd_addr = rbin[ASIZE-1:0] from the register. RAM data for the current address is valid in the cycle rd_fire is high.
- Empty: empty <= (rgray_next == wsync), full-width compare including MSB, so wrap-around is handled.
- Source requirement: wq_gray changes by at most one Gray step per write clock and is glitch-free (registered).
- Flag is pessimistic: empty may stay high after a write for the synchroniser latency. It is never low while the FIFO is actually empty.

## Timing
- Reset values (asynchronous): sync chain 0, rbin 0, rd_gray 0, rd_addr 0, empty 1, rd_level 0, almost_empty 1.
- Write to visible: empty deasserts SYNC_STAGES+1 clk edges after a wq_gray change. With defaults, this is 3 edges.
- Last read: rd_fire on the final word asserts empty at the next edge. No back-to-back read of stale data.
- Read latency: rd_gray updates 1 edge after rd_fire.
- Simultaneous write arrival and last read in the same cycle: the compare uses rgray_next against the current wsync. Empty follows that result and may deassert one cycle later.
- Wrap: pointers roll from 2^(ASIZE+1)-1 to 0 with no flag glitch. A difference of exactly 2^ASIZE (full) is not empty.
- Reset mid-operation: all state returns to reset values immediately. After release, empty recovers SYNC_STAGES+1 edges later if wq_gray is non-zero.

## Configuration
- FIFO_RD_LEVEL_EN defined: adds a Gray-to-binary conversion of wsync, giving wbin.
  - rd_level <= (wbin - rbin_next) mod 2^(ASIZE+1), range 0..2^ASIZE.
  - almost_empty <= (that value <= AE_THRESH).
  - Both are registered and aligned with empty.
- Not defined: the conversion logic is removed, and rd_level and almost_empty are tied to their reset values (0 and 1).
- empty, rd_gray and rd_addr behave identically in both builds.

## Test plan
- Reset: hold reset_n low with wq_gray=5'b00011. Required: empty=1, rd_gray=0, rd_addr=0. These values hold until 3 edges after release.
- Single word: step wq_gray 0→1. Required: empty falls on the 3rd edge. Then pulse rd_en for 1 cycle: rd_addr 0→1, rd_gray=5'b00001, empty=1 on the next edge.
- Underflow: hold rd_en=1 for 10 cycles while empty=1. Required: rd_gray and rd_addr unchanged, empty stays 1.
- Wrap: write and read 40 words, with wq_gray kept one to three steps ahead. Required: rd_addr cycles 0..15 through wrap, rd_gray passes 5'b10000→...→0 via single-bit steps, and empty never asserts while wbin≠rbin.
- Level (macro on): wq_gray=gray(5) stable, no reads. Required: rd_level=5, almost_empty=0. After 3 reads: rd_level=2, almost_empty=1. With macro off: rd_level=0, almost_empty=1 throughout.
- Reset mid-read: level 7, rd_en high, then assert reset_n low asynchronously. Required: all outputs at reset values before the next edge. After release with wq_gray unchanged: empty=0 after 3 edges, and rd_level=7 with the macro on.
